// File: rtl/alu_addsub_if.sv
// Operand/result bundle for the add/subtract/compare unit.
// The master drives operands and control; the slave returns the registered result.
interface alu_addsub_if #(
   parameter int WIDTH = 64
);
   logic             in_valid;
   logic [WIDTH-1:0] in1;
   logic [WIDTH-1:0] in2;
   logic [1:0]       control;
   logic             out_valid;
   logic [WIDTH-1:0] out;
   logic             cout;

   modport master (
      output in_valid, in1, in2, control,
      input  out_valid, out, cout
   );

   modport slave (
      input  in_valid, in1, in2, control,
      output out_valid, out, cout
   );
endinterface

// File: rtl/alu_addsub.sv
// Registered integer add/subtract/compare unit built around a single shared adder.
// Results, carry/borrow and a valid strobe appear one clock after operands are accepted.
module alu_addsub #(
   parameter int WIDTH = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   alu_addsub_if.slave bus
);
   typedef enum logic [1:0] {
      OP_ADD  = 2'b00,
      OP_SUB  = 2'b01,
      OP_SLT  = 2'b10,
      OP_SLTU = 2'b11
   } op_e;

   logic             invert;
   logic [WIDTH-1:0] operandB;
   logic [WIDTH:0]   sumWide;
   logic [WIDTH-1:0] sum;
   logic             carry;
   logic             overflow;
   logic             signedLess;

   logic [WIDTH-1:0] result_d, result_q;
   logic             cout_d,   cout_q;
   logic             valid_q;

   // Every non-ADD operation is in1 + ~in2 + 1, so one adder serves all four.
   assign invert   = (bus.control != OP_ADD);
   assign operandB = invert ? ~bus.in2 : bus.in2;
   assign sumWide  = {1'b0, bus.in1} + {1'b0, operandB} + {{WIDTH{1'b0}}, invert};
   assign sum      = sumWide[WIDTH-1:0];
   assign carry    = sumWide[WIDTH];

   assign overflow   = (bus.in1[WIDTH-1] != bus.in2[WIDTH-1]) &&
                       (sum[WIDTH-1] != bus.in1[WIDTH-1]);
   assign signedLess = sum[WIDTH-1] ^ overflow;

   always_comb begin
      result_d = '0;
      cout_d   = 1'b0;
      case (bus.control)
         OP_ADD: begin
            result_d = sum;
            cout_d   = carry;
         end
         OP_SUB: begin
            // Adder carry-out means "no borrow", so the borrow flag is its inverse.
            result_d = sum;
            cout_d   = ~carry;
         end
         OP_SLT: begin
            result_d = {{(WIDTH-1){1'b0}}, signedLess};
         end
         OP_SLTU: begin
            result_d = {{(WIDTH-1){1'b0}}, ~carry};
         end
         default: begin
            result_d = '0;
            cout_d   = 1'b0;
         end
      endcase
   end

   // Idle cycles keep the last result visible and only drop the valid strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result_q <= '0;
         cout_q   <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         valid_q <= bus.in_valid;
         if (bus.in_valid) begin
            result_q <= result_d;
            cout_q   <= cout_d;
         end
      end
   end

   assign bus.out       = result_q;
   assign bus.cout      = cout_q;
   assign bus.out_valid = valid_q;
endmodule

// File: tb/tb_alu_addsub.sv
// Bench for alu_addsub: directed vector table, reset/streaming sequences,
// and randomized traffic compared against a plain-arithmetic reference model.
module tb_alu_addsub;
   localparam logic [63:0] MAX = 64'hFFFF_FFFF_FFFF_FFFF;

   typedef struct {
      string       name;
      logic [1:0]  ctrl;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] expOut;
      logic        expCout;
   } vec_t;

   logic clk;
   logic rst_n;
   int   testsRun;
   int   testsFailed;
   vec_t vecs[$];

   alu_addsub_if #(.WIDTH(64)) bus ();

   alu_addsub #(.WIDTH(64)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void refModel(input logic [1:0] op, input logic [63:0] a,
                                    input logic [63:0] b, output logic [63:0] r,
                                    output logic c);
      logic [64:0] wide;
      r = '0;
      c = 1'b0;
      case (op)
         2'b00: begin
            wide = {1'b0, a} + {1'b0, b};
            r    = wide[63:0];
            c    = wide[64];
         end
         2'b01: begin
            r = a - b;
            c = (a < b);
         end
         2'b10: r = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
         default: r = (a < b) ? 64'd1 : 64'd0;
      endcase
   endfunction

   function automatic logic [63:0] pickOperand();
      logic [63:0] v;
      case ($urandom_range(0, 5))
         0: v = '0;
         1: v = MAX;
         2: v = 64'h8000_0000_0000_0000;
         3: v = 64'h7FFF_FFFF_FFFF_FFFF;
         default: v = {$urandom, $urandom};
      endcase
      return v;
   endfunction

   task automatic applyStimulus(input logic valid, input logic [1:0] ctrl,
                                input logic [63:0] a, input logic [63:0] b);
      bus.in_valid = valid;
      bus.control  = ctrl;
      bus.in1      = a;
      bus.in2      = b;
   endtask

   task automatic checkOutput(input string name, input logic [63:0] expOut,
                              input logic expCout, input logic expValid);
      testsRun++;
      if (bus.out !== expOut || bus.cout !== expCout || bus.out_valid !== expValid) begin
         testsFailed++;
         $display("[TB] FAIL %s: got out=%h cout=%b valid=%b, expected out=%h cout=%b valid=%b",
                  name, bus.out, bus.cout, bus.out_valid, expOut, expCout, expValid);
      end
   endtask

   initial begin
      logic [63:0] mOut, prevOut;
      logic        mCout, prevCout;
      logic [1:0]  op;
      logic [63:0] a, b;
      logic        v;

      testsRun    = 0;
      testsFailed = 0;

      vecs.push_back('{"add_max_plus_1", 2'b00, MAX, 64'd1, 64'd0, 1'b1});
      vecs.push_back('{"add_max_max", 2'b00, MAX, MAX, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1});
      vecs.push_back('{"add_pattern", 2'b00, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321,
                       64'h2222_2222_2222_2211, 1'b0});
      vecs.push_back('{"sub_8_3", 2'b01, 64'd8, 64'd3, 64'd5, 1'b0});
      vecs.push_back('{"sub_equal", 2'b01, 64'hDEAD_BEEF_0000_1234, 64'hDEAD_BEEF_0000_1234, 64'd0, 1'b0});
      vecs.push_back('{"sub_0_1", 2'b01, 64'd0, 64'd1, MAX, 1'b1});
      vecs.push_back('{"sub_5_10", 2'b01, 64'd5, 64'd10, 64'hFFFF_FFFF_FFFF_FFFB, 1'b1});
      vecs.push_back('{"sub_max_1", 2'b01, MAX, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0});
      vecs.push_back('{"slt_3_5", 2'b10, 64'd3, 64'd5, 64'd1, 1'b0});
      vecs.push_back('{"slt_5_3", 2'b10, 64'd5, 64'd3, 64'd0, 1'b0});
      vecs.push_back('{"slt_7_7", 2'b10, 64'd7, 64'd7, 64'd0, 1'b0});
      vecs.push_back('{"slt_m2_5", 2'b10, 64'hFFFF_FFFF_FFFF_FFFE, 64'd5, 64'd1, 1'b0});
      vecs.push_back('{"slt_5_m2", 2'b10, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 64'd0, 1'b0});
      vecs.push_back('{"slt_m11_m2", 2'b10, 64'hFFFF_FFFF_FFFF_FFF5, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 1'b0});
      vecs.push_back('{"slt_m2_m11", 2'b10, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFF5, 64'd0, 1'b0});
      vecs.push_back('{"slt_minneg_maxpos", 2'b10, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0});
      vecs.push_back('{"sltu_3_5", 2'b11, 64'd3, 64'd5, 64'd1, 1'b0});
      vecs.push_back('{"sltu_7_7", 2'b11, 64'd7, 64'd7, 64'd0, 1'b0});
      vecs.push_back('{"sltu_5_big", 2'b11, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 1'b0});
      vecs.push_back('{"sltu_big_5", 2'b11, 64'hFFFF_FFFF_FFFF_FFFE, 64'd5, 64'd0, 1'b0});
      vecs.push_back('{"sltu_max_maxm1", 2'b11, MAX, 64'hFFFF_FFFF_FFFF_FFFE, 64'd0, 1'b0});
      vecs.push_back('{"sltu_0_1", 2'b11, 64'd0, 64'd1, 64'd1, 1'b0});

      // Reset held with live traffic must keep everything at zero.
      rst_n = 1'b0;
      applyStimulus(1'b1, 2'b00, 64'd5, 64'd3);
      repeat (3) @(posedge clk);
      #1 checkOutput("reset_hold", 64'd0, 1'b0, 1'b0);

      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(1'b1, 2'b00, 64'd5, 64'd3);
      @(posedge clk);
      #1 checkOutput("first_add_5_3", 64'd8, 1'b0, 1'b1);

      foreach (vecs[i]) begin
         applyStimulus(1'b1, vecs[i].ctrl, vecs[i].a, vecs[i].b);
         @(posedge clk);
         #1 checkOutput(vecs[i].name, vecs[i].expOut, vecs[i].expCout, 1'b1);
      end

      // Four back-to-back operations, then an idle cycle that must hold the last result.
      applyStimulus(1'b1, 2'b00, 64'd100, 64'd23);
      @(posedge clk);
      #1 checkOutput("stream_add", 64'd123, 1'b0, 1'b1);
      applyStimulus(1'b1, 2'b01, 64'd3, 64'd4);
      @(posedge clk);
      #1 checkOutput("stream_sub", MAX, 1'b1, 1'b1);
      applyStimulus(1'b1, 2'b10, MAX, 64'd0);
      @(posedge clk);
      #1 checkOutput("stream_slt", 64'd1, 1'b0, 1'b1);
      applyStimulus(1'b1, 2'b11, 64'd2, 64'd9);
      @(posedge clk);
      #1 checkOutput("stream_sltu", 64'd1, 1'b0, 1'b1);
      applyStimulus(1'b0, 2'b00, MAX, MAX);
      @(posedge clk);
      #1 checkOutput("idle_hold_1", 64'd1, 1'b0, 1'b0);
      @(posedge clk);
      #1 checkOutput("idle_hold_2", 64'd1, 1'b0, 1'b0);

      // Reset arriving between edges clears the registered result immediately.
      applyStimulus(1'b1, 2'b00, MAX, MAX);
      @(posedge clk);
      #1 checkOutput("pre_reset_add", 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b1);
      #2 rst_n = 1'b0;
      #1 checkOutput("async_reset", 64'd0, 1'b0, 1'b0);
      @(posedge clk);
      #1 checkOutput("reset_in_flight", 64'd0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      prevOut  = '0;
      prevCout = 1'b0;
      for (int i = 0; i < 400; i++) begin
         v  = ($urandom_range(0, 3) != 0);
         op = 2'($urandom_range(0, 3));
         a  = pickOperand();
         b  = ($urandom_range(0, 7) == 0) ? a : pickOperand();
         applyStimulus(v, op, a, b);
         if (v) begin
            refModel(op, a, b, mOut, mCout);
            prevOut  = mOut;
            prevCout = mCout;
         end
         @(posedge clk);
         #1 checkOutput($sformatf("rand_%0d_op%0d", i, op), prevOut, prevCout, v);
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end
endmodule
